// File: rtl/priority_onehot_iterator.sv
`default_nettype none
// ============================================================================
// Module   : priority_onehot_iterator
// Brief    : Serialises a request vector into one-hot/index outputs, lowest bit
//            first, over valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module priority_onehot_iterator #(
  parameter int WIDTH          = 32,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_vld,
  output logic                     s_rdy,
  input  logic [WIDTH-1:0]         s_pry,
  output logic                     m_vld,
  input  logic                     m_rdy,
  output logic [WIDTH-1:0]         m_oht,
  output logic [$clog2(WIDTH)-1:0] m_bin,
  output logic                     m_lst
);

  localparam int WIDTH_LOG = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_oht;
  logic [WIDTH_LOG-1:0] w_bin;
  logic                 w_lst;
  logic                 w_in_xfer;
  logic                 w_out_xfer;

  generate
    if (IMPLEMENTATION == 0) begin : g_adder
      assign w_oht = r_rem & (~r_rem + WIDTH'(1));
    end else begin : g_scan
      // Descending scan so the lowest set bit is the last one written.
      always_comb begin
        w_oht = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (r_rem[i]) begin
            w_oht    = '0;
            w_oht[i] = 1'b1;
          end
        end
      end
    end
  endgenerate

  // w_oht is one-hot or zero, so an OR of indices is an exact, shallow encoder.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_oht[i]) begin
        w_bin = w_bin | WIDTH_LOG'(i);
      end
    end
  end

  assign w_lst = ((r_rem & ~w_oht) == '0);

  assign m_vld = ~rst & (r_state == EMIT);
  assign s_rdy = ~rst & ((r_state == IDLE) | (w_lst & m_rdy));
  assign m_oht = w_oht;
  assign m_bin = w_bin;
  assign m_lst = w_lst;

  assign w_in_xfer  = s_vld & s_rdy;
  assign w_out_xfer = m_vld & m_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    case (r_state)
      IDLE: begin
        if (w_in_xfer && (s_pry != '0)) begin
          w_rem_nxt   = s_pry;
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (w_out_xfer) begin
          if (!w_lst) begin
            w_rem_nxt = r_rem & ~w_oht;
          end else if (w_in_xfer && (s_pry != '0)) begin
            w_rem_nxt = s_pry;
          end else begin
            w_rem_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_rem_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_onehot_iterator.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_onehot_iterator
// Brief    : Scoreboard bench driving both isolate structures with shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_onehot_iterator;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [7:0] oht;
    logic [2:0] bin;
    logic       lst;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_vld;
  logic [7:0] s_pry;
  logic       m_rdy;

  logic       s_rdy0, m_vld0, m_lst0;
  logic [7:0] m_oht0;
  logic [2:0] m_bin0;
  logic       s_rdy1, m_vld1, m_lst1;
  logic [7:0] m_oht1;
  logic [2:0] m_bin1;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  priority_onehot_iterator #(.WIDTH(WIDTH), .IMPLEMENTATION(0)) dut0 (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy0), .s_pry(s_pry),
    .m_vld(m_vld0), .m_rdy(m_rdy), .m_oht(m_oht0), .m_bin(m_bin0), .m_lst(m_lst0)
  );

  priority_onehot_iterator #(.WIDTH(WIDTH), .IMPLEMENTATION(1)) dut1 (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy1), .s_pry(s_pry),
    .m_vld(m_vld1), .m_rdy(m_rdy), .m_oht(m_oht1), .m_bin(m_bin1), .m_lst(m_lst1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every set bit of the vector in ascending index order.
  task automatic push_vec(input logic [7:0] p);
    int   idx[$];
    exp_t e;
    for (int i = 0; i < WIDTH; i++) begin
      if (p[i]) idx.push_back(i);
    end
    for (int k = 0; k < idx.size(); k++) begin
      e.oht = 8'(1 << idx[k]);
      e.bin = 3'(idx[k]);
      e.lst = (k == idx.size() - 1);
      q.push_back(e);
    end
  endtask

  task automatic chk_dut(input string tag, input logic srdy, input logic mvld,
                         input logic [7:0] oht, input logic [2:0] bin, input logic lst);
    exp_t e;
    if (rst) begin
      chk({tag, ".m_vld_rst"}, 32'(mvld), 32'(0));
      chk({tag, ".s_rdy_rst"}, 32'(srdy), 32'(0));
    end else if (q.size() == 0) begin
      chk({tag, ".m_vld_idle"}, 32'(mvld), 32'(0));
      chk({tag, ".s_rdy_idle"}, 32'(srdy), 32'(1));
      chk({tag, ".m_oht_idle"}, 32'(oht), 32'(0));
      chk({tag, ".m_bin_idle"}, 32'(bin), 32'(0));
      chk({tag, ".m_lst_idle"}, 32'(lst), 32'(1));
    end else begin
      e = q[0];
      chk({tag, ".m_vld"}, 32'(mvld), 32'(1));
      chk({tag, ".m_oht"}, 32'(oht), 32'(e.oht));
      chk({tag, ".m_bin"}, 32'(bin), 32'(e.bin));
      chk({tag, ".m_lst"}, 32'(lst), 32'(e.lst));
      chk({tag, ".s_rdy"}, 32'(srdy), 32'(e.lst & m_rdy));
    end
  endtask

  always @(negedge clk) begin
    chk_dut("adder", s_rdy0, m_vld0, m_oht0, m_bin0, m_lst0);
    chk_dut("scan",  s_rdy1, m_vld1, m_oht1, m_bin1, m_lst1);
    if (!rst && q.size() != 0 && m_rdy) void'(q.pop_front());
  end

  // One clock: sample the input handshake mid-cycle, record acceptance after the edge.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = s_vld && s_rdy0 && !rst;
    @(posedge clk);
    #1;
    if (acc) push_vec(s_pry);
    if (rst) q.delete();
  endtask

  task automatic send(input logic [7:0] p);
    bit acc;
    s_vld = 1'b1;
    s_pry = p;
    for (int n = 0; n < 40; n++) begin
      step(acc);
      if (acc) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: vector %0h not accepted within 40 cycles", p);
  endtask

  task automatic idle(input int n);
    bit acc;
    s_vld = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  initial begin
    bit acc;
    rst   = 1'b1;
    s_vld = 1'b1;
    s_pry = 8'h55;
    m_rdy = 1'b1;
    step(acc);
    step(acc);
    rst = 1'b0;
    idle(2);

    send(8'hA4);
    idle(4);

    m_rdy = 1'b0;
    send(8'hA4);
    idle(3);
    m_rdy = 1'b1;
    idle(4);

    send(8'h00);
    send(8'h01);
    idle(3);

    send(8'h81);
    send(8'hFF);
    idle(11);

    send(8'hF0);
    idle(2);
    rst = 1'b1;
    q.delete();
    step(acc);
    rst = 1'b0;
    idle(4);

    send(8'h80);
    idle(3);

    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 99) < 2);
      s_vld = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       s_pry = 8'h00;
        1:       s_pry = 8'hFF;
        2:       s_pry = 8'(1 << $urandom_range(0, 7));
        default: s_pry = 8'($urandom);
      endcase
      m_rdy = ($urandom_range(0, 9) < 7);
      if (rst) q.delete();
      step(acc);
    end

    rst   = 1'b0;
    s_vld = 1'b0;
    m_rdy = 1'b1;
    for (int n = 0; n < 40 && q.size() != 0; n++) step(acc);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still expected, required 0", q.size());
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
